ufp_wdata_merge: RTL and testbench
==================================

UFP_WDATA_MERGE -- requirements
Module: ufp_wdata_merge

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset, sampled on rising edge of clk.
REQ-003 SHALL have port ufp_wvalid, input, 1, CPU-side write request valid.
REQ-004 SHALL have ports ufp_addr (input, 32, byte address), ufp_wmask (input, 4, byte enables) and ufp_wdata (input, 32, write word).
REQ-005 SHALL have port way_select, input, 2, hit way for the current write.
REQ-006 SHALL have ports ufp_wready (output, 1, write accepted this cycle) and ufp_resp (output, 1, write-complete pulse).
REQ-007 SHALL have port array_free, input, 1, data-array write port available this cycle.
REQ-008 SHALL have ports data_csb (output, 4, per-way chip select, active-low) and data_web (output, 4, per-way write enable, active-low).
REQ-009 SHALL have ports data_addr (output, 4, set index), data_wmask (output, 32, byte enables) and data_din (output, 256, line data).
REQ-010 SHALL have ports dirty_we (output, 1), dirty_set (output, 4) and dirty_way (output, 2), which set the dirty bit.
REQ-011 SHALL have ports rd_set (input, 4), rd_way (input, 2), fwd_hit (output, 1), fwd_mask (output, 32) and fwd_data (output, 256), used for read forwarding.

Function
REQ-012 SHALL decode set = ufp_addr[8:5] and word = ufp_addr[4:2]; ufp_addr[1:0] ignored.
REQ-013 SHALL expand each write into a 256-bit line: ufp_wdata placed at bits word*32 +: 32, ufp_wmask placed at byte-mask bits word*4 +: 4, all other mask bits 0.
REQ-014 SHALL hold a single-entry buffer with states EMPTY and FULL, storing set, way, a 32-bit mask and 256-bit data.
REQ-015 SHALL drain the buffer when state is FULL and array_free=1: data_csb[way]=0 and data_web[way]=0 with the buffered addr/mask/data, and dirty_we=1 with dirty_set/dirty_way, all in the same cycle.
REQ-016 SHALL drive data_csb and data_web all-ones and dirty_we=0 in every cycle with no drain.
REQ-017 SHALL compute ufp_wready combinationally: 1 when EMPTY, or when draining this cycle, or when FULL with a coalesce hit (same set and same way as the buffer).
REQ-018 SHALL load the expanded write into the buffer on accept (ufp_wvalid & ufp_wready) from EMPTY, or when drain and accept occur in the same cycle; state becomes FULL.
REQ-019 SHALL coalesce on a hit with no drain: for each byte, the new byte and mask bit win when the new mask bit is 1; otherwise the buffered byte is kept; mask is OR-ed.
REQ-020 SHALL give drain priority over coalesce when both apply in one cycle: the drained line excludes the new write, and the buffer reloads with the new write only.
REQ-021 SHALL go FULL->EMPTY when a drain occurs with no accept.
REQ-022 SHALL assert ufp_resp for exactly one cycle, the cycle after each accept; ufp_wvalid with wmask=0 is accepted and buffered like any other write.
REQ-023 SHALL NOT drain and accept again the same buffered line twice; one drain per buffer fill.

Reset
REQ-024 SHALL on rst: state EMPTY, buffer mask 0, ufp_resp 0, data_csb/data_web 4'b1111, dirty_we 0, fwd_hit 0.
REQ-025 SHALL discard a FULL buffer on rst mid-operation, without a drain, and SHALL NOT respond to a write presented in the reset cycle.

Configuration
REQ-026 SHALL compile forwarding in when UFP_WBUF_FWD_EN is defined: fwd_hit=1 when FULL and {rd_set,rd_way} match the buffer, with fwd_mask/fwd_data equal to the buffer contents (combinational).
REQ-027 SHALL tie fwd_hit=0, fwd_mask=0 and fwd_data=0 when UFP_WBUF_FWD_EN is undefined; all other behaviour is unchanged.

Verification
REQ-028 SHALL test single write: addr 0x0000_0024, wmask 4'b0011, wdata 0xAABBCCDD, way 2, array_free=1 next cycle -> ufp_resp pulses; one cycle later data_csb=4'b1011, data_addr=1, data_wmask=32'h0000_0030, data_din[47:32]=16'hCCDD.
REQ-029 SHALL test coalesce: array_free=0, writes to set 3 way 1 at word 0 (mask 1111) and word 0 (mask 0001, data 0x11) -> a single drain where byte0=0x11, bytes1-3 are from the first write, and mask=32'hF.
REQ-030 SHALL test full stall: FULL set 3 way 1, array_free=0, write to set 4 -> ufp_wready=0 until array_free=1; in that cycle the drain and accept occur together.
REQ-031 SHALL test reset mid-operation: FULL, then rst for 1 cycle, then array_free=1 -> no data_web assertion and state EMPTY.
REQ-032 SHALL test forwarding with UFP_WBUF_FWD_EN defined: FULL set 5 way 0, rd_set=5, rd_way=0 -> fwd_hit=1 and fwd_mask equal to the buffer mask; with the macro undefined, fwd_hit=0.

Source files
------------

// File: rtl/ufp_wdata_merge.sv
// Single-entry write buffer that coalesces CPU word writes into a cache line and drains it to the data array.
// Optional read forwarding from the buffer is compiled in with `define UFP_WBUF_FWD_EN.
module ufp_wdata_merge (
  input  logic         clk,
  input  logic         rst,
  input  logic         ufp_wvalid,
  input  logic [31:0]  ufp_addr,
  input  logic [3:0]   ufp_wmask,
  input  logic [31:0]  ufp_wdata,
  input  logic [1:0]   way_select,
  output logic         ufp_wready,
  output logic         ufp_resp,
  input  logic         array_free,
  output logic [3:0]   data_csb,
  output logic [3:0]   data_web,
  output logic [3:0]   data_addr,
  output logic [31:0]  data_wmask,
  output logic [255:0] data_din,
  output logic         dirty_we,
  output logic [3:0]   dirty_set,
  output logic [1:0]   dirty_way,
  input  logic [3:0]   rd_set,
  input  logic [1:0]   rd_way,
  output logic         fwd_hit,
  output logic [31:0]  fwd_mask,
  output logic [255:0] fwd_data
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state, state_next;
  logic [3:0]     buf_set;
  logic [1:0]     buf_way;
  logic [31:0]    buf_mask;
  logic [255:0]   buf_data;

  logic [3:0]     wr_set;
  logic [2:0]     wr_word;
  logic [31:0]    new_mask, merged_mask;
  logic [255:0]   new_data, merged_data;
  logic           drain, coalesce_hit, accept, load, merge;

  assign wr_set  = ufp_addr[8:5];
  assign wr_word = ufp_addr[4:2];

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    new_mask = '0;
    new_data = '0;
    new_mask[{wr_word, 2'b00} +: 4]  = ufp_wmask;
    new_data[{wr_word, 5'b00000} +: 32] = ufp_wdata;
  end

  always_comb begin
    merged_mask = buf_mask | new_mask;
    merged_data = buf_data;
    for (int i = 0; i < 32; i++) begin
      if (new_mask[i]) merged_data[i*8 +: 8] = new_data[i*8 +: 8];
    end
  end

  // A write presented during reset is never accepted, and a held line is dropped rather than drained.
  assign drain        = (state == FULL) && array_free && !rst;
  assign coalesce_hit = (state == FULL) && (wr_set == buf_set) && (way_select == buf_way);
  assign ufp_wready   = !rst && ((state == EMPTY) || drain || coalesce_hit);
  assign accept       = ufp_wvalid && ufp_wready;
  // Drain wins over coalesce: the outgoing line excludes the new write, which starts a fresh line.
  assign load         = accept && ((state == EMPTY) || drain);
  assign merge        = accept && !load;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept)           state_next = FULL;
      FULL:  if (drain && !accept) state_next = EMPTY;
      default:                     state_next = EMPTY;
    endcase
  end

  always_comb begin
    data_csb = 4'hF;
    data_web = 4'hF;
    dirty_we = 1'b0;
    if (drain) begin
      data_csb[buf_way] = 1'b0;
      data_web[buf_way] = 1'b0;
      dirty_we          = 1'b1;
    end
  end

  assign data_addr  = buf_set;
  assign data_wmask = buf_mask;
  assign data_din   = buf_data;
  assign dirty_set  = buf_set;
  assign dirty_way  = buf_way;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_mask <= '0;
      ufp_resp <= 1'b0;
    end else begin
      ufp_resp <= accept;
      if (load)       buf_mask <= new_mask;
      else if (merge) buf_mask <= merged_mask;
    end
  end

  // NOTE: the wide line payload is left unreset; the mask and state qualify it.
  always_ff @(posedge clk) begin
    if (!rst && load) begin
      buf_set  <= wr_set;
      buf_way  <= way_select;
      buf_data <= new_data;
    end else if (!rst && merge) begin
      buf_data <= merged_data;
    end
  end

`ifdef UFP_WBUF_FWD_EN
  assign fwd_hit  = !rst && (state == FULL) && (rd_set == buf_set) && (rd_way == buf_way);
  assign fwd_mask = buf_mask;
  assign fwd_data = buf_data;

  logic unused_addr;
  assign unused_addr = ^{ufp_addr[31:9], ufp_addr[1:0]};
`else
  assign fwd_hit  = 1'b0;
  assign fwd_mask = '0;
  assign fwd_data = '0;

  logic unused_in;
  assign unused_in = ^{ufp_addr[31:9], ufp_addr[1:0], rd_set, rd_way};
`endif

endmodule

// File: tb/tb_ufp_wdata_merge.sv
// Self-checking bench for ufp_wdata_merge: directed scenarios plus randomized traffic against a byte-level model.
module tb_ufp_wdata_merge;

  logic         clk = 1'b0;
  logic         rst, ufp_wvalid, array_free;
  logic [31:0]  ufp_addr, ufp_wdata;
  logic [3:0]   ufp_wmask;
  logic [1:0]   way_select, rd_way;
  logic [3:0]   rd_set;
  logic         ufp_wready, ufp_resp, dirty_we, fwd_hit;
  logic [3:0]   data_csb, data_web, data_addr, dirty_set;
  logic [31:0]  data_wmask, fwd_mask;
  logic [255:0] data_din, fwd_data;
  logic [1:0]   dirty_way;

  int checks = 0;
  int errors = 0;

  ufp_wdata_merge dut (
    .clk(clk), .rst(rst), .ufp_wvalid(ufp_wvalid), .ufp_addr(ufp_addr),
    .ufp_wmask(ufp_wmask), .ufp_wdata(ufp_wdata), .way_select(way_select),
    .ufp_wready(ufp_wready), .ufp_resp(ufp_resp), .array_free(array_free),
    .data_csb(data_csb), .data_web(data_web), .data_addr(data_addr),
    .data_wmask(data_wmask), .data_din(data_din), .dirty_we(dirty_we),
    .dirty_set(dirty_set), .dirty_way(dirty_way), .rd_set(rd_set), .rd_way(rd_way),
    .fwd_hit(fwd_hit), .fwd_mask(fwd_mask), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  // Reference model: whole-line buffer kept as 32 independent bytes with a valid bit each.
  bit       m_full, m_resp;
  int       m_set, m_way;
  bit [7:0] m_byte [32];
  bit       m_mbit [32];

  function automatic logic [31:0] model_mask();
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = m_mbit[i];
    return r;
  endfunction

  function automatic logic [255:0] model_data();
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[i*8 +: 8] = m_byte[i];
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ufp_wvalid = 0; ufp_addr = 0; ufp_wmask = 0; ufp_wdata = 0;
    way_select = 0; array_free = 0; rd_set = 0; rd_way = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    next_cycle();
    next_cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (data_csb !== 4'hF) begin errors++; $display("FAIL reset_csb: got %h expected f", data_csb); end
    checks++; if (data_web !== 4'hF) begin errors++; $display("FAIL reset_web: got %h expected f", data_web); end
    checks++; if (dirty_we !== 1'b0) begin errors++; $display("FAIL reset_dirty_we: got %b expected 0", dirty_we); end
    checks++; if (ufp_resp !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b expected 0", ufp_resp); end
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd_hit: got %b expected 0", fwd_hit); end
    checks++; if (ufp_wready !== 1'b1) begin errors++; $display("FAIL reset_wready: got %b expected 1", ufp_wready); end
    next_cycle();
  endtask

  task automatic test_single_write();
    do_reset();
    ufp_wvalid = 1; ufp_addr = 32'h0000_0024; ufp_wmask = 4'b0011;
    ufp_wdata = 32'hAABBCCDD; way_select = 2;
    @(negedge clk);
    checks++; if (ufp_wready !== 1'b1) begin errors++; $display("FAIL single_wready: got %b expected 1", ufp_wready); end
    next_cycle();
    ufp_wvalid = 0; array_free = 1;
    @(negedge clk);
    checks++; if (ufp_resp !== 1'b1) begin errors++; $display("FAIL single_resp: got %b expected 1", ufp_resp); end
    checks++; if (data_csb !== 4'b1011) begin errors++; $display("FAIL single_csb: got %b expected 1011", data_csb); end
    checks++; if (data_web !== 4'b1011) begin errors++; $display("FAIL single_web: got %b expected 1011", data_web); end
    checks++; if (data_addr !== 4'd1) begin errors++; $display("FAIL single_addr: got %0d expected 1", data_addr); end
    checks++; if (data_wmask !== 32'h0000_0030) begin errors++; $display("FAIL single_wmask: got %h expected 00000030", data_wmask); end
    checks++; if (data_din[47:32] !== 16'hCCDD) begin errors++; $display("FAIL single_din: got %h expected ccdd", data_din[47:32]); end
    checks++; if ({dirty_we, dirty_set, dirty_way} !== {1'b1, 4'd1, 2'd2}) begin errors++; $display("FAIL single_dirty: got %b/%0d/%0d expected 1/1/2", dirty_we, dirty_set, dirty_way); end
    next_cycle();
    @(negedge clk);
    checks++; if (ufp_resp !== 1'b0) begin errors++; $display("FAIL single_resp_pulse: got %b expected 0", ufp_resp); end
    checks++; if (data_web !== 4'hF) begin errors++; $display("FAIL single_no_redrain: got %b expected 1111", data_web); end
    array_free = 0;
    next_cycle();
  endtask

  task automatic test_coalesce();
    do_reset();
    array_free = 0;
    ufp_wvalid = 1; ufp_addr = 32'h0000_0060; ufp_wmask = 4'hF; ufp_wdata = 32'hDDCCBBAA; way_select = 1;
    next_cycle();
    ufp_wmask = 4'b0001; ufp_wdata = 32'h0000_0011;
    @(negedge clk);
    checks++; if (ufp_wready !== 1'b1) begin errors++; $display("FAIL coalesce_wready: got %b expected 1", ufp_wready); end
    checks++; if (data_web !== 4'hF) begin errors++; $display("FAIL coalesce_early_drain: got %b expected 1111", data_web); end
    next_cycle();
    ufp_wvalid = 0; array_free = 1;
    @(negedge clk);
    checks++; if (data_csb !== 4'b1101) begin errors++; $display("FAIL coalesce_csb: got %b expected 1101", data_csb); end
    checks++; if (data_wmask !== 32'h0000_000F) begin errors++; $display("FAIL coalesce_wmask: got %h expected 0000000f", data_wmask); end
    checks++; if (data_din[31:0] !== 32'hDDCCBB11) begin errors++; $display("FAIL coalesce_din: got %h expected ddccbb11", data_din[31:0]); end
    next_cycle();
    @(negedge clk);
    checks++; if (data_csb !== 4'hF) begin errors++; $display("FAIL coalesce_single_drain: got %b expected 1111", data_csb); end
    array_free = 0;
    next_cycle();
  endtask

  task automatic test_full_stall();
    do_reset();
    ufp_wvalid = 1; ufp_addr = 32'h0000_0060; ufp_wmask = 4'hF; ufp_wdata = 32'hCAFEF00D; way_select = 1;
    next_cycle();
    ufp_addr = 32'h0000_0080; ufp_wdata = 32'h12345678;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (ufp_wready !== 1'b0) begin errors++; $display("FAIL stall_wready_%0d: got %b expected 0", c, ufp_wready); end
      next_cycle();
    end
    array_free = 1;
    @(negedge clk);
    checks++; if (ufp_wready !== 1'b1) begin errors++; $display("FAIL stall_release_wready: got %b expected 1", ufp_wready); end
    checks++; if ({data_csb, data_addr} !== {4'b1101, 4'd3}) begin errors++; $display("FAIL stall_drain_old: got %b/%0d expected 1101/3", data_csb, data_addr); end
    checks++; if (data_din[31:0] !== 32'hCAFEF00D) begin errors++; $display("FAIL stall_drain_data: got %h expected cafef00d", data_din[31:0]); end
    next_cycle();
    ufp_wvalid = 0;
    @(negedge clk);
    checks++; if (ufp_resp !== 1'b1) begin errors++; $display("FAIL stall_resp: got %b expected 1", ufp_resp); end
    checks++; if ({data_csb, data_addr, data_wmask} !== {4'b1101, 4'd4, 32'hF}) begin errors++; $display("FAIL stall_drain_new: got %b/%0d/%h expected 1101/4/0000000f", data_csb, data_addr, data_wmask); end
    checks++; if (data_din[31:0] !== 32'h12345678) begin errors++; $display("FAIL stall_new_data: got %h expected 12345678", data_din[31:0]); end
    array_free = 0;
    next_cycle();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    ufp_wvalid = 1; ufp_addr = 32'h0000_0060; ufp_wmask = 4'hF; ufp_wdata = 32'h01020304; way_select = 1;
    next_cycle();
    ufp_wvalid = 0;
    next_cycle();
    rst = 1; array_free = 1; ufp_wvalid = 1; ufp_addr = 32'h0000_0040;
    @(negedge clk);
    checks++; if (data_web !== 4'hF) begin errors++; $display("FAIL rstmid_web_in_reset: got %b expected 1111", data_web); end
    checks++; if (ufp_wready !== 1'b0) begin errors++; $display("FAIL rstmid_wready_in_reset: got %b expected 0", ufp_wready); end
    next_cycle();
    rst = 0; ufp_wvalid = 0;
    @(negedge clk);
    checks++; if (data_web !== 4'hF) begin errors++; $display("FAIL rstmid_web_after: got %b expected 1111", data_web); end
    checks++; if (ufp_resp !== 1'b0) begin errors++; $display("FAIL rstmid_resp: got %b expected 0", ufp_resp); end
    checks++; if (ufp_wready !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %b expected 1", ufp_wready); end
    array_free = 0;
    next_cycle();
  endtask

  task automatic test_forwarding();
    logic        exp_hit;
    logic [31:0] exp_mask;
`ifdef UFP_WBUF_FWD_EN
    exp_hit = 1'b1; exp_mask = 32'h0000_0F00;
`else
    exp_hit = 1'b0; exp_mask = 32'h0;
`endif
    do_reset();
    ufp_wvalid = 1; ufp_addr = 32'h0000_00A8; ufp_wmask = 4'hF; ufp_wdata = 32'h55AA55AA; way_select = 0;
    next_cycle();
    ufp_wvalid = 0; rd_set = 5; rd_way = 0;
    @(negedge clk);
    checks++; if (fwd_hit !== exp_hit) begin errors++; $display("FAIL fwd_hit: got %b expected %b", fwd_hit, exp_hit); end
    checks++; if (fwd_mask !== exp_mask) begin errors++; $display("FAIL fwd_mask: got %h expected %h", fwd_mask, exp_mask); end
    rd_way = 1;
    @(negedge clk);
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_way_miss: got %b expected 0", fwd_hit); end
    array_free = 1;
    next_cycle();
    array_free = 0;
    next_cycle();
  endtask

  task automatic test_random();
    bit       e_drain, e_hit, e_ready, e_fwd, acc;
    int       set_i, word_i;
    do_reset();
    m_full = 0; m_resp = 0;
    for (int i = 0; i < 32; i++) begin m_mbit[i] = 0; m_byte[i] = 0; end
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 63) == 0);
      ufp_wvalid = ($urandom_range(0, 2) != 0);
      ufp_addr   = $urandom;
      ufp_addr[8:5] = 4'($urandom_range(0, 2));
      ufp_wmask  = 4'($urandom);
      ufp_wdata  = $urandom;
      way_select = 2'($urandom_range(0, 1));
      array_free = ($urandom_range(0, 3) == 0);
      rd_set     = 4'($urandom_range(0, 2));
      rd_way     = 2'($urandom_range(0, 1));
      set_i  = int'(ufp_addr[8:5]);
      word_i = int'(ufp_addr[4:2]);

      e_drain = !rst && m_full && array_free;
      e_hit   = m_full && set_i == m_set && int'(way_select) == m_way;
      e_ready = !rst && (!m_full || e_drain || e_hit);
`ifdef UFP_WBUF_FWD_EN
      e_fwd = !rst && m_full && int'(rd_set) == m_set && int'(rd_way) == m_way;
`else
      e_fwd = 0;
`endif
      @(negedge clk);
      checks++; if (ufp_wready !== e_ready) begin errors++; $display("FAIL rnd_wready @%0d: got %b expected %b", n, ufp_wready, e_ready); end
      checks++; if (ufp_resp !== m_resp) begin errors++; $display("FAIL rnd_resp @%0d: got %b expected %b", n, ufp_resp, m_resp); end
      checks++; if (data_web !== (e_drain ? ~(4'b1 << m_way) : 4'hF)) begin errors++; $display("FAIL rnd_web @%0d: got %b drain %b", n, data_web, e_drain); end
      checks++; if (data_csb !== data_web || dirty_we !== e_drain) begin errors++; $display("FAIL rnd_csb_dirty @%0d: got %b/%b expected drain %b", n, data_csb, dirty_we, e_drain); end
      if (e_drain) begin
        checks++; if ({data_addr, dirty_set, dirty_way} !== {4'(m_set), 4'(m_set), 2'(m_way)}) begin errors++; $display("FAIL rnd_drain_addr @%0d: got %0d/%0d/%0d expected %0d/%0d", n, data_addr, dirty_set, dirty_way, m_set, m_way); end
        checks++; if (data_wmask !== model_mask()) begin errors++; $display("FAIL rnd_drain_mask @%0d: got %h expected %h", n, data_wmask, model_mask()); end
        checks++; if (data_din !== model_data()) begin errors++; $display("FAIL rnd_drain_data @%0d: got %h expected %h", n, data_din, model_data()); end
      end
      checks++; if (fwd_hit !== e_fwd) begin errors++; $display("FAIL rnd_fwd_hit @%0d: got %b expected %b", n, fwd_hit, e_fwd); end
      if (e_fwd) begin
        checks++; if (fwd_mask !== model_mask() || fwd_data !== model_data()) begin errors++; $display("FAIL rnd_fwd_line @%0d: got %h expected %h", n, fwd_mask, model_mask()); end
      end
      @(posedge clk);
      if (rst) begin
        m_full = 0; m_resp = 0;
        for (int i = 0; i < 32; i++) m_mbit[i] = 0;
      end else begin
        acc    = ufp_wvalid && e_ready;
        m_resp = acc;
        if (acc && (!m_full || e_drain)) begin
          for (int i = 0; i < 32; i++) begin m_mbit[i] = 0; m_byte[i] = 0; end
          for (int b = 0; b < 4; b++) begin
            m_byte[word_i*4 + b] = ufp_wdata[b*8 +: 8];
            m_mbit[word_i*4 + b] = ufp_wmask[b];
          end
          m_full = 1; m_set = set_i; m_way = int'(way_select);
        end else if (acc) begin
          for (int b = 0; b < 4; b++) begin
            if (ufp_wmask[b]) begin
              m_byte[word_i*4 + b] = ufp_wdata[b*8 +: 8];
              m_mbit[word_i*4 + b] = 1;
            end
          end
        end else if (e_drain) begin
          m_full = 0;
        end
      end
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_coalesce();
    test_full_stall();
    test_reset_mid_op();
    test_forwarding();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
